// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: two-port round-robin arbiter in front of a single-port data memory
module data_memory_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic [CNT_W-1:0]  count0,
  output logic [CNT_W-1:0]  count1
);
  typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;
  state_t state_q, state_d;
  logic last_q, last_d;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic [CNT_W-1:0] count0_q, count1_q;
  // state and last-grant register; last grant starts at 1 so port 0 wins the first tie
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  // next state: from a service the other port goes first, so continuous requesters alternate
  always_comb begin
    state_d = IDLE;
    if (state_q == SERVE0) state_d = req1 ? SERVE1 : req0 ? SERVE0 : IDLE;
    else if (state_q == SERVE1) state_d = req0 ? SERVE0 : req1 ? SERVE1 : IDLE;
    else state_d = (req0 && req1) ? (last_q ? SERVE0 : SERVE1) : req0 ? SERVE0 : req1 ? SERVE1 : IDLE;
    last_d = (state_d == SERVE0) ? 1'b0 : (state_d == SERVE1) ? 1'b1 : last_q;
  end
  // outputs depend only on state, so an async reset drops mem_we before the next edge
  always_comb begin
    done0       = state_q == SERVE0;
    done1       = state_q == SERVE1;
    busy        = state_q != IDLE;
    mem_address = done0 ? addr0 : done1 ? addr1 : '0;
    mem_din     = done0 ? wdata0 : done1 ? wdata1 : '0;
    mem_we      = done0 ? we0 : done1 ? we1 : 1'b0;
  end
  // per-port read capture and access counting at the edge ending a service
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
      count0_q <= '0;
      count1_q <= '0;
    end else begin
      if (state_q == SERVE0) begin
        if (!we0) rdata0_q <= mem_dout;
        count0_q <= count0_q + 1'b1;
      end
      if (state_q == SERVE1) begin
        if (!we1) rdata1_q <= mem_dout;
        count1_q <= count1_q + 1'b1;
      end
    end
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign count0 = count0_q;
  assign count1 = count1_q;
endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: directed vectors plus multi-cycle sequences against a behavioural memory
module tb_data_memory_arbiter;
  logic clk = 0, reset = 1, preload = 1;
  logic req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [4:0] addr0 = 0, addr1 = 0;
  logic [63:0] wdata0 = 0, wdata1 = 0;
  logic done0, done1, mem_we, busy;
  logic [63:0] rdata0, rdata1, mem_din, mem_dout;
  logic [4:0] mem_address;
  logic [15:0] count0, count1;
  logic [63:0] mem [32];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  data_memory_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .done0(done0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .done1(done1), .rdata1(rdata1),
    .mem_address(mem_address), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
    .busy(busy), .count0(count0), .count1(count1)
  );

  always @(posedge clk)
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= 64'd0;
      mem[1] <= 64'd10;
      mem[2] <= 64'd20;
      mem[4] <= 64'd40;
      mem[5] <= -64'sd10;
    end else if (mem_we) mem[mem_address] <= mem_din;
  assign mem_dout = mem[mem_address];

  typedef struct {
    logic port; logic we; logic [4:0] addr; logic [63:0] wdata;
    logic [63:0] e_r0, e_r1; logic [15:0] e_c0, e_c1;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int waits;
    logic got, we_seen, d;
    @(posedge clk); #1;
    if (v.port) begin req1 = 1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; end
    else begin req0 = 1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; end
    waits = 0; got = 0; we_seen = 0;
    for (int c = 0; c < 6 && !got; c++) begin
      @(negedge clk);
      we_seen = we_seen | mem_we;
      d = v.port ? done1 : done0;
      if (d) begin got = 1; req0 = 0; req1 = 0; end
      else waits++;
    end
    chk("served", got, 1);
    chk("wait_cycles", waits, 1);
    chk("mem_we_seen", we_seen, v.we);
    @(negedge clk);
    chk("done_once", v.port ? done1 : done0, 0);
    chk("busy_after", busy, 0);
    chk("rdata0", rdata0, v.e_r0);
    chk("rdata1", rdata1, v.e_r1);
    chk("count0", count0, v.e_c0);
    chk("count1", count1, v.e_c1);
  endtask

  initial begin
    int n;
    vec_t w;
    vt[0] = '{0, 0, 5'd1, 64'd0, 64'd10, 64'd0, 16'd1, 16'd0};
    vt[1] = '{1, 1, 5'd3, 64'hDEAD_BEEF, 64'd10, 64'd0, 16'd1, 16'd1};
    vt[2] = '{0, 0, 5'd3, 64'd0, 64'hDEAD_BEEF, 64'd0, 16'd2, 16'd1};
    vt[3] = '{1, 0, 5'd2, 64'd0, 64'hDEAD_BEEF, 64'd20, 16'd2, 16'd2};
    vt[4] = '{0, 1, 5'd7, 64'h123, 64'hDEAD_BEEF, 64'd20, 16'd3, 16'd2};
    vt[5] = '{1, 0, 5'd7, 64'd0, 64'hDEAD_BEEF, 64'h123, 16'd3, 16'd3};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done0", done0, 0);
    chk("rst_done1", done1, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_count0", count0, 0);
    chk("rst_count1", count1, 0);
    @(posedge clk); #1;
    reset = 0; preload = 0;

    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // simultaneous loads: port 0 first, port 1 the very next cycle
    @(posedge clk); #1;
    req0 = 1; we0 = 0; addr0 = 5; req1 = 1; we1 = 0; addr1 = 2;
    @(negedge clk);
    chk("sim_wait_idle", busy, 0);
    @(negedge clk);
    chk("sim_first_done0", done0, 1);
    chk("sim_first_done1", done1, 0);
    req0 = 0;
    @(negedge clk);
    chk("sim_second_done1", done1, 1);
    chk("sim_second_done0", done0, 0);
    req1 = 0;
    @(negedge clk);
    chk("sim_busy_after", busy, 0);
    chk("sim_rdata0", rdata0, 64'hFFFF_FFFF_FFFF_FFF6);
    chk("sim_rdata1", rdata1, 64'd20);
    chk("sim_count0", count0, 16'd4);
    chk("sim_count1", count1, 16'd4);

    // both held for 8 services: strict alternation starting at port 0
    @(posedge clk); #1;
    req0 = 1; addr0 = 1; req1 = 1; addr1 = 3;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("alt_done0", done0, (i % 2) == 0);
      chk("alt_done1", done1, (i % 2) == 1);
      chk("alt_busy", busy, 1);
      if (i == 7) begin req0 = 0; req1 = 0; end
    end
    @(negedge clk);
    chk("alt_busy_after", busy, 0);
    chk("alt_count0", count0, 16'd8);
    chk("alt_count1", count1, 16'd8);
    chk("alt_rdata0", rdata0, 64'd10);
    chk("alt_rdata1", rdata1, 64'hDEAD_BEEF);

    // reset in the middle of a port 1 store: the write must not commit
    @(posedge clk); #1;
    req1 = 1; we1 = 1; addr1 = 4; wdata1 = 64'h999;
    @(posedge clk); #2;
    chk("mid_mem_we_before", mem_we, 1);
    #1 reset = 1;
    #1;
    chk("mid_mem_we_after", mem_we, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done1", done1, 0);
    chk("mid_mem_address", mem_address, 0);
    req1 = 0; we1 = 0;
    @(posedge clk); #1;
    chk("mid_mem4", mem[4], 64'd40);
    chk("mid_count0", count0, 0);
    chk("mid_count1", count1, 0);
    chk("mid_rdata0", rdata0, 0);
    chk("mid_rdata1", rdata1, 0);
    reset = 0;

    // single requester held high: served every cycle, counter wraps
    @(posedge clk); #1;
    req0 = 1; we0 = 0; addr0 = 1;
    n = 0;
    for (int c = 0; c < 65600 && n < 65535; c++) begin
      @(negedge clk);
      if (done0) begin
        n++;
        if (n == 65535) req0 = 0;
      end
    end
    chk("wrap_services", n, 65535);
    @(negedge clk);
    chk("wrap_count_max", count0, 16'hFFFF);
    w = '{0, 0, 5'd1, 64'd0, 64'd10, 64'd0, 16'd0, 16'd0};
    run_vec(w);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
